// File: rtl/ics_pkg.sv
// Shared constants, FSM encodings and address-field helpers for the
// instruction-cache refill sequencer (ics_refill_ctrl, ics_refill_cnt).
package ics_pkg;

   localparam int ADDR_WIDTH   = 16;
   localparam int DATA_WIDTH   = 16;
   localparam int LINE_WORDS   = 4;
   localparam int INDEX_WIDTH  = 4;
   localparam int OFFSET_WIDTH = $clog2(LINE_WORDS);
   localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   // One extra bit so a count of LINE_WORDS is representable.
   localparam int CNT_WIDTH    = OFFSET_WIDTH + 1;

   localparam logic [1:0] STATE_IDLE   = 2'd0;
   localparam logic [1:0] STATE_FILL   = 2'd1;
   localparam logic [1:0] STATE_COMMIT = 2'd2;

   function automatic logic [TAG_WIDTH-1:0] addr_tag(
      input logic [ADDR_WIDTH-1:0] a
   );
      return a[ADDR_WIDTH-1 -: TAG_WIDTH];
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] addr_index(
      input logic [ADDR_WIDTH-1:0] a
   );
      return a[OFFSET_WIDTH +: INDEX_WIDTH];
   endfunction

   function automatic logic [OFFSET_WIDTH-1:0] addr_offset(
      input logic [ADDR_WIDTH-1:0] a
   );
      return a[OFFSET_WIDTH-1:0];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] line_base(
      input logic [ADDR_WIDTH-1:0] a
   );
      return {a[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/ics_refill_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a done flag
// raised when the count equals LIMIT.
// Ports: clk, arst (async, active-high), clr, en -> cnt, done.
module ics_refill_cnt #(
   parameter int WIDTH = 3,
   parameter int LIMIT = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             done
);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   assign done = (cnt == WIDTH'(LIMIT));

endmodule

// File: rtl/ics_refill_ctrl.sv
// I-cache miss/refill sequencer: latches a missing line, issues pipelined
// word reads, writes returned words into the data array, commits the tag.
// Ports: clk, arst; i_halt; i_miss/i_miss_addr in; o_miss_state out;
// memory request (o_mem_req_*, i_mem_req_ready) and response (i_mem_rsp_*);
// data-array write (o_data_*) and tag-array write (o_tag_*).
module ics_refill_ctrl
   import ics_pkg::*;
(
   input  logic                              clk,
   input  logic                              arst,
   input  logic                              i_halt,
   input  logic                              i_miss,
   input  logic [ADDR_WIDTH-1:0]             i_miss_addr,
   output logic                              o_miss_state,
   output logic [ADDR_WIDTH-1:0]             o_mem_req_addr,
   output logic                              o_mem_req_valid,
   input  logic                              i_mem_req_ready,
   input  logic [DATA_WIDTH-1:0]             i_mem_rsp_data,
   input  logic                              i_mem_rsp_valid,
   output logic                              o_data_we,
   output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_data_waddr,
   output logic [DATA_WIDTH-1:0]             o_data_wdata,
   output logic                              o_tag_we,
   output logic [INDEX_WIDTH-1:0]            o_tag_windex,
   output logic [TAG_WIDTH:0]                o_tag_wdata
);

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic                  miss_state;
   logic [CNT_WIDTH-1:0]  req_cnt;
   logic [CNT_WIDTH-1:0]  rsp_cnt;
   logic                  req_done;
   logic                  rsp_done;

   logic in_idle;
   logic in_fill;
   logic in_commit;
   logic accept;
   logic req_fire;
   logic rsp_take;
   logic rsp_last;
   logic fill_done;

   assign in_idle   = (state == STATE_IDLE);
   assign in_fill   = (state == STATE_FILL);
   assign in_commit = (state == STATE_COMMIT);

   assign accept   = in_idle & ~i_halt & i_miss;
   assign req_fire = o_mem_req_valid & i_mem_req_ready;
   // Memory cannot be stalled, so capture ignores i_halt.
   assign rsp_take = in_fill & i_mem_rsp_valid & ~rsp_done;
   assign rsp_last = (rsp_cnt == CNT_WIDTH'(LINE_WORDS - 1));
   // Either the final word lands this cycle, or it landed while halted.
   assign fill_done = ~i_halt & (rsp_done | (rsp_take & rsp_last));

   ics_refill_cnt #(
      .WIDTH (CNT_WIDTH),
      .LIMIT (LINE_WORDS)
   ) u_req_cnt (
      .clk  (clk),
      .arst (arst),
      .clr  (accept),
      .en   (req_fire),
      .cnt  (req_cnt),
      .done (req_done)
   );

   ics_refill_cnt #(
      .WIDTH (CNT_WIDTH),
      .LIMIT (LINE_WORDS)
   ) u_rsp_cnt (
      .clk  (clk),
      .arst (arst),
      .clr  (accept),
      .en   (rsp_take),
      .cnt  (rsp_cnt),
      .done (rsp_done)
   );

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         in_idle:   if (accept)    state_nxt = STATE_FILL;
         in_fill:   if (fill_done) state_nxt = STATE_COMMIT;
         in_commit: if (!i_halt)   state_nxt = STATE_IDLE;
         default:                  state_nxt = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= STATE_IDLE;
         base       <= '0;
         miss_state <= 1'b0;
      end else begin
         state      <= state_nxt;
         miss_state <= (state_nxt != STATE_IDLE);
         if (accept) begin
            base <= line_base(i_miss_addr);
         end
      end
   end

   assign o_miss_state = miss_state;

   assign o_mem_req_valid = in_fill & ~i_halt & ~req_done;
   // req_cnt only reaches LINE_WORDS once valid has dropped.
   assign o_mem_req_addr  = o_mem_req_valid
                          ? (base | ADDR_WIDTH'(req_cnt))
                          : '0;

   assign o_data_we    = rsp_take;
   assign o_data_waddr = rsp_take
                       ? {addr_index(base), rsp_cnt[OFFSET_WIDTH-1:0]}
                       : '0;
   assign o_data_wdata = rsp_take ? i_mem_rsp_data : '0;

   assign o_tag_we     = in_commit & ~i_halt;
   assign o_tag_windex = o_tag_we ? addr_index(base) : '0;
   assign o_tag_wdata  = o_tag_we ? {1'b1, addr_tag(base)} : '0;

endmodule

// File: tb/tb_ics_refill_ctrl.sv
// Scoreboard bench for ics_refill_ctrl: randomized misses, memory
// readiness, latency and halts against a line-level reference model.
module tb_ics_refill_ctrl;
   import ics_pkg::*;

   logic                                 clk;
   logic                                 arst;
   logic                                 i_halt;
   logic                                 i_miss;
   logic [ADDR_WIDTH-1:0]                i_miss_addr;
   logic                                 o_miss_state;
   logic [ADDR_WIDTH-1:0]                o_mem_req_addr;
   logic                                 o_mem_req_valid;
   logic                                 i_mem_req_ready;
   logic [DATA_WIDTH-1:0]                i_mem_rsp_data;
   logic                                 i_mem_rsp_valid;
   logic                                 o_data_we;
   logic [INDEX_WIDTH+OFFSET_WIDTH-1:0]  o_data_waddr;
   logic [DATA_WIDTH-1:0]                o_data_wdata;
   logic                                 o_tag_we;
   logic [INDEX_WIDTH-1:0]               o_tag_windex;
   logic [TAG_WIDTH:0]                   o_tag_wdata;

   ics_refill_ctrl dut (
      .clk             (clk),
      .arst            (arst),
      .i_halt          (i_halt),
      .i_miss          (i_miss),
      .i_miss_addr     (i_miss_addr),
      .o_miss_state    (o_miss_state),
      .o_mem_req_addr  (o_mem_req_addr),
      .o_mem_req_valid (o_mem_req_valid),
      .i_mem_req_ready (i_mem_req_ready),
      .i_mem_rsp_data  (i_mem_rsp_data),
      .i_mem_rsp_valid (i_mem_rsp_valid),
      .o_data_we       (o_data_we),
      .o_data_waddr    (o_data_waddr),
      .o_data_wdata    (o_data_wdata),
      .o_tag_we        (o_tag_we),
      .o_tag_windex    (o_tag_windex),
      .o_tag_wdata     (o_tag_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   logic [15:0] salt;
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] m;
      m = a * 16'd40503;
      return m ^ salt;
   endfunction

   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];
   int    cyc = 0;
   int    ready_mode = 0;
   int    lat_min = 2;
   int    lat_max = 2;

   // Memory: in-order responses, fixed or random latency.
   initial begin
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         case (ready_mode)
            0:       i_mem_req_ready = 1'b1;
            1:       i_mem_req_ready = (cyc % 2) == 0;
            default: i_mem_req_ready = 1'($urandom_range(1, 0));
         endcase
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_data  = 16'($urandom);
         end
      end
   end

   // Reference model state: line-level view of the refill.
   logic [15:0] exp_req[$];
   logic [63:0] exp_data[$];
   logic [63:0] exp_tag[$];
   bit          busy = 1'b0;
   int          accepts = 0;
   int          commits = 0;
   int          reqs_acc = 0;
   int          writes = 0;
   int          line_reqs = 0;
   int          line_writes = 0;
   int          first_req_cyc = 0;
   int          last_req_cyc = 0;

   // Monitor: samples mid-cycle, pops and compares.
   initial begin
      forever begin
         @(negedge clk);
         if (arst) begin
            busy = 1'b0;
            exp_req.delete();
            exp_data.delete();
            exp_tag.delete();
            chk("rst_outs_a", {o_miss_state, o_mem_req_valid, o_data_we,
                               o_tag_we, o_mem_req_addr, o_data_wdata},
                64'd0);
            chk("rst_outs_b", {o_data_waddr, o_tag_windex, o_tag_wdata},
                64'd0);
         end else begin
            bit busy_n;
            busy_n = busy;
            chk("miss_state", o_miss_state, busy);
            if (i_halt) begin
               chk("halt_req_valid", o_mem_req_valid, 0);
               chk("halt_tag_we", o_tag_we, 0);
            end
            if (o_mem_req_valid) begin
               if (exp_req.size() == 0) begin
                  chk("req_unexpected", 1, 0);
               end else begin
                  chk("req_addr", o_mem_req_addr, exp_req[0]);
                  if (i_mem_req_ready) begin
                     pend_t p;
                     p.addr = o_mem_req_addr;
                     p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                     pend.push_back(p);
                     void'(exp_req.pop_front());
                     if (line_reqs == 0) first_req_cyc = cyc;
                     last_req_cyc = cyc;
                     line_reqs++;
                     reqs_acc++;
                  end
               end
            end
            if (o_data_we) begin
               if (exp_data.size() == 0) begin
                  chk("data_unexpected", 1, 0);
               end else begin
                  line_writes++;
                  chk("rsp_le_req", line_writes <= line_reqs, 1);
                  chk("data_write", {o_data_waddr, o_data_wdata},
                      exp_data.pop_front());
               end
               writes++;
            end
            if (o_tag_we) begin
               if (exp_tag.size() == 0) begin
                  chk("tag_unexpected", 1, 0);
               end else begin
                  chk("tag_write", {o_tag_windex, o_tag_wdata},
                      exp_tag.pop_front());
                  chk("tag_after_fill", exp_req.size() + exp_data.size(),
                      0);
               end
               commits++;
               busy_n = 1'b0;
            end
            if (i_miss && !i_halt && !busy) begin
               int base;
               int idx;
               int tag;
               base = int'(i_miss_addr) / LINE_WORDS * LINE_WORDS;
               idx  = (int'(i_miss_addr) / LINE_WORDS) % (1 << INDEX_WIDTH);
               tag  = int'(i_miss_addr) / (LINE_WORDS << INDEX_WIDTH);
               for (int w = 0; w < LINE_WORDS; w++) begin
                  exp_req.push_back(16'(base + w));
                  exp_data.push_back(64'(((idx * LINE_WORDS + w)
                                          << DATA_WIDTH)
                                         | int'(mem_word(16'(base + w)))));
               end
               exp_tag.push_back(64'((idx << (TAG_WIDTH + 1))
                                     | (1 << TAG_WIDTH) | tag));
               line_reqs   = 0;
               line_writes = 0;
               accepts++;
               busy_n = 1'b1;
            end
            busy = busy_n;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [15:0] a);
      i_miss      = 1'b1;
      i_miss_addr = a;
      step();
      i_miss      = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while ((busy || exp_req.size() != 0 || exp_tag.size() != 0)
             && k < 400) begin
         step();
         k++;
      end
      chk({nm, "_timeout"}, k < 400, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int c0;
      int a0;
      int w0;
      int r0;
      salt        = 16'($urandom);
      arst        = 1'b1;
      i_halt      = 1'b0;
      i_miss      = 1'b0;
      i_miss_addr = '0;
      repeat (3) step();
      arst = 1'b0;
      step();

      // Directed miss, always-ready memory, 2-cycle latency.
      c0 = commits;
      do_miss(16'h1236);
      wait_idle("p1");
      chk("p1_commits", commits - c0, 1);
      chk("p1_req_span", last_req_cyc - first_req_cyc, LINE_WORDS - 1);

      // Ready toggling every cycle.
      ready_mode = 1;
      step();
      do_miss(16'($urandom));
      wait_idle("p2");

      // Halt for 3 cycles after 2 requests have gone out.
      ready_mode = 0;
      step();
      r0 = reqs_acc;
      do_miss(16'hBEEF);
      k = 0;
      while (reqs_acc - r0 < 2 && k < 50) begin
         step();
         k++;
      end
      w0 = writes;
      i_halt = 1'b1;
      repeat (3) step();
      chk("p3_halt_writes", writes - w0, 2);
      chk("p3_halt_reqs", reqs_acc - r0, 2);
      i_halt = 1'b0;
      wait_idle("p3");

      // Stray miss during FILL is ignored.
      c0 = commits;
      a0 = accepts;
      do_miss(16'h4321);
      repeat (2) step();
      i_miss      = 1'b1;
      i_miss_addr = 16'h9870;
      step();
      i_miss = 1'b0;
      wait_idle("p4");
      chk("p4_commits", commits - c0, 1);
      chk("p4_accepts", accepts - a0, 1);

      // Reset after two responses; late responses must be dropped.
      c0 = commits;
      w0 = writes;
      do_miss(16'h0AB5);
      k = 0;
      while (writes - w0 < 2 && k < 50) begin
         step();
         k++;
      end
      arst = 1'b1;
      repeat (2) step();
      arst = 1'b0;
      k = 0;
      while (pend.size() != 0 && k < 50) begin
         step();
         k++;
      end
      repeat (2) step();
      chk("p5_no_commit", commits - c0, 0);
      do_miss(16'h7F3A);
      wait_idle("p5");
      chk("p5_commits", commits - c0, 1);

      // Back-to-back: miss held high across the commit.
      c0 = commits;
      a0 = accepts;
      i_miss      = 1'b1;
      i_miss_addr = 16'h2222;
      step();
      i_miss_addr = 16'h5559;
      k = 0;
      while (commits == c0 && k < 100) begin
         step();
         k++;
      end
      step();
      i_miss = 1'b0;
      wait_idle("p6");
      chk("p6_accepts", accepts - a0, 2);
      chk("p6_commits", commits - c0, 2);

      // Random traffic with halts and stray misses.
      ready_mode = 2;
      lat_min    = 1;
      lat_max    = 4;
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(3, 0)) step();
         do_miss(16'($urandom));
         k = 0;
         while (busy && k < 300) begin
            i_halt      = ($urandom_range(4, 0) == 0);
            i_miss      = ($urandom_range(3, 0) == 0);
            i_miss_addr = 16'($urandom);
            step();
            k++;
         end
         i_halt = 1'b0;
         i_miss = 1'b0;
         wait_idle("rand");
      end

      repeat (4) step();
      chk("queues_empty", exp_req.size() + exp_data.size()
                          + exp_tag.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
